// File: rtl/asic_cfg_serializer_if.sv
// Command/response bundle between a host and the configuration serializer.
//
// Handshake: a command transfers on a rising clock edge where in_valid and
// in_ready are both 1. The host holds in_word/in_ch/in_verify stable while
// in_valid is 1 and may keep in_valid high across commands; in_ready is 1
// only while the serializer is idle and out of reset. done is a one-cycle
// pulse; rsp_xor/rsp_mismatch are valid while done=1 and held until the
// next done.
interface asic_cfg_serializer_if #(
    parameter int DATA_W = 16,
    parameter int N_CH   = 4
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_word;
    logic [CH_W-1:0]   in_ch;
    logic              in_verify;
    logic              done;
    logic [DATA_W-1:0] rsp_xor;
    logic              rsp_mismatch;
    logic [7:0]        mismatch_cnt;

    modport master (
        output in_valid, in_word, in_ch, in_verify,
        input  in_ready, done, rsp_xor, rsp_mismatch, mismatch_cnt
    );

    modport slave (
        input  in_valid, in_word, in_ch, in_verify,
        output in_ready, done, rsp_xor, rsp_mismatch, mismatch_cnt
    );
endinterface

// File: rtl/asic_cfg_serializer.sv
// Serial configuration writer for N_CH target ASICs sharing sclk/mosi/miso.
// A command shifts a DATA_W word MSB first to one lane; in verify mode the
// word is sent twice and the second half of miso is captured and compared
// against the written word.
module asic_cfg_serializer #(
    parameter int DATA_W  = 16,
    parameter int N_CH    = 4,
    parameter int CLK_DIV = 2
) (
    input  logic                CLK,
    input  logic                RST,
    asic_cfg_serializer_if.slave cmd,
    output logic                sclk,
    output logic                mosi,
    output logic [N_CH-1:0]     sel_n,
    input  logic                miso,
    output logic [2:0]          state_o
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(2 * DATA_W + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_HIGH   = 3'd2,
        S_LOW    = 3'd3,
        S_HOLD   = 3'd4,
        S_REPORT = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q;
    logic [CNT_W-1:0]  bits_q;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] cap_q;
    logic [CH_W-1:0]   ch_q;
    logic              verify_q;
    logic [DATA_W-1:0] rsp_xor_q;
    logic              rsp_mm_q;
    logic [7:0]        cnt_q;

    logic              div_last;
    logic              last_bit;
    logic              accept;
    logic              sample_now;
    logic              readback;
    logic [DATA_W-1:0] diff;
    logic [N_CH-1:0]   lane_sel_n;

    // div_q counts the cycles spent in the current timed phase.
    assign div_last   = (div_q == DIV_W'(CLK_DIV - 1));
    // bits_q holds the number of bits still to send, including the current one.
    assign last_bit   = (bits_q == CNT_W'(1));
    assign accept     = cmd.in_valid & cmd.in_ready;
    // miso is looked at once per bit, in the first cycle sclk is high.
    assign sample_now = (state_q == S_HIGH) && (div_q == '0);
    // Only the second copy of the word carries readback data.
    assign readback   = verify_q && (bits_q <= CNT_W'(DATA_W));
    assign diff       = word_q ^ cap_q;
    assign lane_sel_n = ~(N_CH'(1) << ch_q);

    assign cmd.rsp_xor      = rsp_xor_q;
    assign cmd.rsp_mismatch = rsp_mm_q;
    assign cmd.mismatch_cnt = cnt_q;
    assign state_o          = state_q;

    // State register; reset aborts any frame in flight.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state sequencing of the frame phases.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept)   state_d = S_SETUP;
            S_SETUP:  if (div_last) state_d = S_HIGH;
            S_HIGH:   if (div_last) state_d = last_bit ? S_HOLD : S_LOW;
            S_LOW:    if (div_last) state_d = S_HIGH;
            S_HOLD:   if (div_last) state_d = S_REPORT;
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Pin and handshake outputs decoded from the current state.
    always_comb begin
        cmd.in_ready = 1'b0;
        cmd.done     = 1'b0;
        sclk         = 1'b0;
        mosi         = 1'b0;
        sel_n        = '1;
        case (state_q)
            S_IDLE:   cmd.in_ready = ~RST;
            S_SETUP: begin
                sel_n = lane_sel_n;
                mosi  = sh_q[DATA_W-1];
            end
            S_HIGH: begin
                sel_n = lane_sel_n;
                mosi  = sh_q[DATA_W-1];
                sclk  = 1'b1;
            end
            S_LOW, S_HOLD: begin
                sel_n = lane_sel_n;
                mosi  = sh_q[DATA_W-1];
            end
            S_REPORT: cmd.done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: command latch, bit shifting, readback capture and response.
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_q     <= '0;
            bits_q    <= '0;
            word_q    <= '0;
            sh_q      <= '0;
            cap_q     <= '0;
            ch_q      <= '0;
            verify_q  <= 1'b0;
            rsp_xor_q <= '0;
            rsp_mm_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (state_q == S_IDLE || state_q == S_REPORT || div_last) div_q <= '0;
            else                                                      div_q <= div_q + 1'b1;

            if (accept) begin
                word_q   <= cmd.in_word;
                sh_q     <= cmd.in_word;
                ch_q     <= cmd.in_ch;
                verify_q <= cmd.in_verify;
                bits_q   <= cmd.in_verify ? CNT_W'(2 * DATA_W) : CNT_W'(DATA_W);
                cap_q    <= '0;
            end

            if (sample_now && readback) cap_q <= {cap_q[DATA_W-2:0], miso};

            // Rotating rather than shifting leaves the word intact for the
            // second pass of a verify frame.
            if (state_q == S_HIGH && div_last && !last_bit) begin
                sh_q   <= {sh_q[DATA_W-2:0], sh_q[DATA_W-1]};
                bits_q <= bits_q - 1'b1;
            end

            // Response is loaded on entry to REPORT so it is valid with done.
            if (state_q == S_HOLD && div_last) begin
                if (verify_q) begin
                    rsp_xor_q <= diff;
                    rsp_mm_q  <= |diff;
                    if ((|diff) && (cnt_q != 8'hFF)) cnt_q <= cnt_q + 8'd1;
                end else begin
                    rsp_xor_q <= '0;
                    rsp_mm_q  <= 1'b0;
                end
            end
        end
    end
endmodule
